// File: rtl/video_pkg.sv
// Shared timing constants, timing record and FSM state for the video timing generator.
// Defaults describe 1080p60; helper function sums one axis of a timing record.
package video_pkg;

    localparam int CNT_W   = 12;
    localparam int CNT_LIM = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } timing_t;

    localparam timing_t DEF_1080P = '{
        h: '{DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP},
        v: '{DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP}
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } vtg_state_e;

    function automatic int axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video output bus: blanking, syncs, pixel position and frame-start pulse.
// master drives the bus (timing generator), slave consumes it.
interface video_timing_gen_if;
    import video_pkg::*;

    logic [1:0]       vh_blank_o;
    logic [2:0]       dvh_sync_o;
    logic [CNT_W-1:0] hcount_o;
    logic [CNT_W-1:0] vcount_o;
    logic             frame_start_o;

    modport master (
        output vh_blank_o, dvh_sync_o, hcount_o, vcount_o, frame_start_o
    );

    modport slave (
        input vh_blank_o, dvh_sync_o, hcount_o, vcount_o, frame_start_o
    );
endinterface

// File: rtl/video_axis_cnt.sv
// Wrap counter 0..TOTAL-1 with terminal-count flag and next-value output.
// Ports: clk_i, rst_n_i, en_i (advance), clr_i (force 0), cnt_o, nxt_o, tc_o.
module video_axis_cnt
    import video_pkg::*;
#(
    parameter int TOTAL = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] nxt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: IDLE/RUN/DRAIN frame sequencer, whole frames only.
// Ports: clk_i, rst_n_i, cen_i, run_i, busy_o, vid (video bus, master).
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_1080P.h.active,
    parameter int   H_FP     = DEF_1080P.h.fp,
    parameter int   H_SYNC   = DEF_1080P.h.sync,
    parameter int   H_BP     = DEF_1080P.h.bp,
    parameter int   V_ACTIVE = DEF_1080P.v.active,
    parameter int   V_FP     = DEF_1080P.v.fp,
    parameter int   V_SYNC   = DEF_1080P.v.sync,
    parameter int   V_BP     = DEF_1080P.v.bp,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cen_i,
    input  logic               run_i,
    output logic               busy_o,
    video_timing_gen_if.master vid
);

    localparam timing_t TM = '{
        h: '{H_ACTIVE, H_FP, H_SYNC, H_BP},
        v: '{V_ACTIVE, V_FP, V_SYNC, V_BP}
    };
    localparam int H_TOTAL = axis_total(TM.h);
    localparam int V_TOTAL = axis_total(TM.v);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    if (H_TOTAL > CNT_LIM || V_TOTAL > CNT_LIM) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end

    vtg_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic             h_tc, v_tc, last_px;
    logic             adv, clr;
    logic             act_d, hb_d, vb_d, hs_on, vs_on;
    logic [1:0]       blank_q, blank_d;
    logic [2:0]       sync_q, sync_d;
    logic             fs_q, fs_d;

    assign last_px = h_tc & v_tc;

    // A frame only ends on its last pixel; run_i is only sampled there
    // or when leaving IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (run_i) state_d = ST_RUN;
            ST_RUN:   if (!run_i) state_d = last_px ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (run_i)
                    state_d = ST_RUN;
                else if (last_px)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Leaving IDLE presents (0,0) with counters still at 0, so the
    // counters only advance while both current and next state are live.
    assign adv = cen_i & (state_q != ST_IDLE) & (state_d != ST_IDLE);
    assign clr = cen_i & (state_d == ST_IDLE);

    video_axis_cnt #(.TOTAL(H_TOTAL)) u_hcnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (adv),
        .clr_i   (clr),
        .cnt_o   (h_cnt),
        .nxt_o   (h_nxt),
        .tc_o    (h_tc)
    );

    video_axis_cnt #(.TOTAL(V_TOTAL)) u_vcnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (adv & h_tc),
        .clr_i   (clr),
        .cnt_o   (v_cnt),
        .nxt_o   (v_nxt),
        .tc_o    (v_tc)
    );

    // Decode the next position so flags register alongside the counters.
    always_comb begin
        act_d   = (state_d != ST_IDLE);
        hb_d    = !act_d || (int'(h_nxt) >= H_ACTIVE);
        vb_d    = !act_d || (int'(v_nxt) >= V_ACTIVE);
        hs_on   = act_d && (int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END);
        vs_on   = act_d && (int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END);
        blank_d = {vb_d, hb_d};
        sync_d  = {~(hb_d | vb_d),
                   vs_on ? SYNC_POL : ~SYNC_POL,
                   hs_on ? SYNC_POL : ~SYNC_POL};
        fs_d    = act_d && (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            blank_q <= 2'b11;
            sync_q  <= {1'b0, ~SYNC_POL, ~SYNC_POL};
            fs_q    <= 1'b0;
        end else if (cen_i) begin
            state_q <= state_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
            fs_q    <= fs_d;
        end
    end

    assign busy_o            = (state_q != ST_IDLE);
    assign vid.vh_blank_o    = blank_q;
    assign vid.dvh_sync_o    = sync_q;
    assign vid.hcount_o      = h_cnt;
    assign vid.vcount_o      = v_cnt;
    assign vid.frame_start_o = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small 16x8 raster, both sync polarities side by side.
// A pixel-index frame model predicts every output after each clock edge.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HTOT  = HA + HF + HS + HB;
    localparam int VTOT  = VA + VF + VS + VB;
    localparam int FRAME = HTOT * VTOT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b0;
    logic run = 1'b0;
    logic busy1, busy0;

    video_timing_gen_if if1();
    video_timing_gen_if if0();

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .cen_i(cen), .run_i(run),
        .busy_o(busy1), .vid(if1.master)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .cen_i(cen), .run_i(run),
        .busy_o(busy0), .vid(if0.master)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: generator on/off plus pixel index within the frame.
    bit m_on = 1'b0;
    int m_p = 0;

    wire [61:0] obs = {
        busy1, if1.vh_blank_o, if1.dvh_sync_o, if1.hcount_o, if1.vcount_o, if1.frame_start_o,
        busy0, if0.vh_blank_o, if0.dvh_sync_o, if0.hcount_o, if0.vcount_o, if0.frame_start_o
    };

    function automatic logic [30:0] expv(input logic pol);
        int h, v;
        logic hb, vb, hs, vs;
        if (!m_on)
            return {1'b0, 2'b11, 1'b0, ~pol, ~pol, 24'd0, 1'b0};
        h  = m_p % HTOT;
        v  = m_p / HTOT;
        hb = (h >= HA);
        vb = (v >= VA);
        hs = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
        vs = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
        return {1'b1, vb, hb, ~(hb | vb), vs, hs, 12'(h), 12'(v), m_p == 0};
    endfunction

    function automatic logic [61:0] expall();
        return {expv(1'b1), expv(1'b0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n && cen) begin
            if (!m_on) begin
                if (run) begin
                    m_on = 1'b1;
                    m_p  = 0;
                end
            end else if (m_p == FRAME - 1 && !run)
                m_on = 1'b0;
            else
                m_p = (m_p + 1) % FRAME;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b0; run = 1'b0;
        m_on = 1'b0; m_p = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (obs !== expall()) begin
            miscompares++;
            $display("FAIL reset got %h want %h", obs, expall());
        end
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        tick();
        vectors++;
        if (obs !== expall()) begin
            miscompares++;
            $display("FAIL reset_cen0 got %h want %h", obs, expall());
        end
    endtask

    task automatic test_frame();
        int ds_cnt = 0;
        int fs_at[$];
        cen = 1'b1; run = 1'b1;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL frame i=%0d got %h want %h", i, obs, expall());
            end
            if (i < FRAME && if1.dvh_sync_o[2]) ds_cnt++;
            if (if1.frame_start_o) fs_at.push_back(i);
        end
        vectors++;
        if (ds_cnt !== HA * VA) begin
            miscompares++;
            $display("FAIL dsync_count got %0d want %0d", ds_cnt, HA * VA);
        end
        vectors++;
        if (fs_at.size() < 2 || fs_at[1] - fs_at[0] !== FRAME) begin
            miscompares++;
            $display("FAIL frame_period starts %0d want gap %0d", fs_at.size(), FRAME);
        end
    endtask

    task automatic test_half_rate();
        run = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            cen = (i % 2 == 0);
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL half_rate i=%0d got %h want %h", i, obs, expall());
            end
        end
        cen = 1'b1;
    endtask

    task automatic test_drain();
        int k;
        logic [23:0] last_pos = '0;
        cen = 1'b1; run = 1'b1;
        for (k = 0; k < 3 * FRAME && !(m_on && m_p == 2 * HTOT + 3); k++) begin
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL drain_pre got %h want %h", obs, expall());
            end
        end
        if (k == 3 * FRAME) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout_a got none want (3,2)");
        end
        run = 1'b0;
        for (k = 0; k < 2 * FRAME && m_on; k++) begin
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL drain got %h want %h", obs, expall());
            end
            if (busy1) last_pos = {if1.hcount_o, if1.vcount_o};
        end
        vectors++;
        if (last_pos !== {12'(HTOT - 1), 12'(VTOT - 1)}) begin
            miscompares++;
            $display("FAIL drain_last got %h want %h", last_pos, {12'(HTOT - 1), 12'(VTOT - 1)});
        end
        repeat (5) tick();
        vectors++;
        if ({busy1, if1.vh_blank_o, busy0, if0.vh_blank_o} !== 6'b011_011) begin
            miscompares++;
            $display("FAIL drain_idle got %b want 011011",
                     {busy1, if1.vh_blank_o, busy0, if0.vh_blank_o});
        end
        run = 1'b1;
        for (k = 0; k < 2 * FRAME && !(m_on && m_p == HTOT); k++) tick();
        run = 1'b0;
        for (k = 0; k < 2 * FRAME && !(m_on && m_p == 6 * HTOT + 5); k++) begin
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL rearm got %h want %h", obs, expall());
            end
        end
        run = 1'b1;
        for (k = 1; k < 2 * FRAME; k++) begin
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL rearm_run got %h want %h", obs, expall());
            end
            if (if1.frame_start_o) break;
        end
        vectors++;
        if (k !== FRAME - (6 * HTOT + 5)) begin
            miscompares++;
            $display("FAIL rearm_gap got %0d want %0d", k, FRAME - (6 * HTOT + 5));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) run = ~run;
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL random i=%0d got %h want %h", i, obs, expall());
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        cen = 1'b1; run = 1'b1;
        for (k = 0; k < 3 * FRAME && !(m_on && m_p == 3 * HTOT + 6); k++) tick();
        vectors++;
        if (obs !== expall() || k == 3 * FRAME) begin
            miscompares++;
            $display("FAIL areset_pre got %h want %h", obs, expall());
        end
        #2;
        cen = 1'b0;
        rst_n = 1'b0;
        m_on = 1'b0; m_p = 0;
        #1;
        vectors++;
        if (obs !== expall()) begin
            miscompares++;
            $display("FAIL areset got %h want %h", obs, expall());
        end
        @(negedge clk);
        rst_n = 1'b1;
        cen = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++;
            if (obs !== expall()) begin
                miscompares++;
                $display("FAIL restart i=%0d got %h want %h", i, obs, expall());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_half_rate();
        test_drain();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
